// File: rtl/stall_pipe_array.sv
// NUM_CH independent lanes, each a DEPTH-stage +1-per-stage pipeline, sharing one global stall.
// Optional macro STALL_COUNTER_EN builds a saturating stall-cycle counter on stall_count.
module stall_pipe_array #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     in_ready,
    output logic [NUM_CH-1:0]        out_valid,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic                     stall,
    output logic [31:0]              stall_count
);

    // Handshake: a beat enters lane i on a posedge with in_valid[i] & in_ready, and leaves
    // lane i on a posedge with out_valid[i] & out_ready[i]; any blocked output freezes all lanes.
    logic [DEPTH-1:0]  vld [NUM_CH];
    logic [DATA_W-1:0] dat [NUM_CH][DEPTH];
    logic              advance;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane_out
        assign out_valid[g]                   = vld[g][DEPTH-1];
        assign out_data[g*DATA_W +: DATA_W]   = dat[g][DEPTH-1];
    end

    assign stall    = |(out_valid & ~out_ready);
    assign in_ready = ~stall & ~flush;
    assign advance  = in_ready;

    // Stage 0 already holds in_data + 1 so the last stage delivers in_data + DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                vld[i] <= '0;
                for (int k = 0; k < DEPTH; k++) begin
                    dat[i][k] <= '0;
                end
            end
        end else if (flush) begin
            for (int i = 0; i < NUM_CH; i++) begin
                vld[i] <= '0;
            end
        end else if (advance) begin
            for (int i = 0; i < NUM_CH; i++) begin
                vld[i][0] <= in_valid[i];
                dat[i][0] <= in_data[i*DATA_W +: DATA_W] + DATA_W'(1);
                for (int k = 1; k < DEPTH; k++) begin
                    vld[i][k] <= vld[i][k-1];
                    dat[i][k] <= dat[i][k-1] + DATA_W'(1);
                end
            end
        end
    end

`ifdef STALL_COUNTER_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 32'd0;
        end else if (stall && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_count = stall_cnt;
`else
    assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_stall_pipe_array.sv
// Bench for stall_pipe_array: directed sequences, a wrap table and random traffic
// checked every cycle against a queue-based model of beats and their advance age.
module tb_stall_pipe_array;

    localparam int NUM_CH = 2;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic                     clk;
    logic                     reset;
    logic                     flush;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic                     in_ready;
    logic [NUM_CH-1:0]        out_valid;
    logic [NUM_CH*DATA_W-1:0] out_data;
    logic [NUM_CH-1:0]        out_ready;
    logic                     stall;
    logic [31:0]              stall_count;

    stall_pipe_array #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .stall(stall), .stall_count(stall_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    // Each accepted beat remembers the advance count at acceptance; it is at the output
    // once DEPTH advances have happened since, and leaves on the next advance.
    typedef struct {
        logic [31:0] data;
        int          tag;
    } beat_t;

    beat_t       mq [NUM_CH][$];
    int          adv_cnt = 0;
    logic [31:0] m_cnt   = 32'd0;

    function automatic logic [NUM_CH-1:0] m_valid();
        logic [NUM_CH-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            v[i] = (mq[i].size() > 0) && (adv_cnt - mq[i][0].tag == DEPTH);
        end
        return v;
    endfunction

    always @(posedge clk) begin
        logic [NUM_CH-1:0] v;
        logic              st;
        v  = m_valid();
        st = |(v & ~out_ready);
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) mq[i].delete();
            m_cnt = 32'd0;
        end else begin
            if (st && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (flush) begin
                for (int i = 0; i < NUM_CH; i++) mq[i].delete();
            end else if (!st) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    beat_t b;
                    if (v[i]) void'(mq[i].pop_front());
                    if (in_valid[i]) begin
                        b.data = in_data[i*DATA_W +: DATA_W] + 32'd4;
                        b.tag  = adv_cnt;
                        mq[i].push_back(b);
                    end
                end
                adv_cnt++;
            end
        end
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [NUM_CH-1:0] v;
        logic              st;
        if (chk_en && !reset) begin
            v  = m_valid();
            st = |(v & ~out_ready);
            check("out_valid", 64'(out_valid), 64'(v));
            for (int i = 0; i < NUM_CH; i++) begin
                if (v[i]) check($sformatf("out_data[%0d]", i), 64'(out_data[i*DATA_W +: DATA_W]), 64'(mq[i][0].data));
            end
            check("stall", 64'(stall), 64'(st));
            check("in_ready", 64'(in_ready), 64'(!st && !flush));
`ifdef STALL_COUNTER_EN
            check("stall_count", 64'(stall_count), 64'(m_cnt));
`else
            check("stall_count", 64'(stall_count), 64'd0);
`endif
        end
    end

    // lane-0 delivery log for the streaming latency check
    bit          log_en = 1'b0;
    logic [31:0] log_d[$];
    int          log_c[$];

    always @(negedge clk) begin
        if (log_en && out_valid[0] && out_ready[0]) begin
            log_d.push_back(out_data[31:0]);
            log_c.push_back(cyc);
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[5];
    logic [63:0] snap_d;
    logic [1:0]  snap_v;
    int          t0;

    initial begin
        vecs[0] = '{din: 32'h0000_0000, exp: 32'h0000_0004};
        vecs[1] = '{din: 32'hFFFF_FFFE, exp: 32'h0000_0002};
        vecs[2] = '{din: 32'hFFFF_FFFC, exp: 32'h0000_0000};
        vecs[3] = '{din: 32'hFFFF_FFFF, exp: 32'h0000_0003};
        vecs[4] = '{din: 32'h1234_5678, exp: 32'h1234_567C};

        reset = 1'b1; flush = 1'b0; in_valid = '0; in_data = '0; out_ready = 2'b11;
        step(); step();
        reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_data", 64'(out_data), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset stall", 64'(stall), 64'd0);
        check("reset stall_count", 64'(stall_count), 64'd0);

        // stream 0..9 on lane 0
        step();
        log_en = 1'b1;
        in_valid = 2'b01;
        for (int j = 0; j < 10; j++) begin
            in_data[31:0] = 32'(j);
            if (j == 0) t0 = cyc;
            step();
        end
        in_valid = '0;
        repeat (8) step();
        log_en = 1'b0;
        check("stream count", 64'(log_d.size()), 64'd10);
        for (int j = 0; j < 10 && j < log_d.size(); j++) begin
            check($sformatf("stream data %0d", j), 64'(log_d[j]), 64'(j + 4));
            check($sformatf("stream cycle %0d", j), 64'(log_c[j]), 64'(t0 + DEPTH + j));
        end

        // wrap table, lane 1 idle with out_ready[1] = 0
        out_ready = 2'b01;
        for (int j = 0; j < 5; j++) begin
            in_valid = 2'b01;
            in_data[31:0] = vecs[j].din;
            step();
            in_valid = '0;
            repeat (DEPTH - 1) step();
            @(negedge clk);
            check($sformatf("wrap valid %0d", j), 64'(out_valid), 64'b01);
            check($sformatf("wrap data %0d", j), 64'(out_data[31:0]), 64'(vecs[j].exp));
            check($sformatf("wrap stall %0d", j), 64'(stall), 64'd0);
            step();
        end

        // flush mid-stream with a same-cycle input
        out_ready = 2'b11;
        in_valid = 2'b11;
        for (int n = 0; n < 6; n++) begin
            in_data = {32'(200 + n), 32'(100 + n)};
            step();
        end
        flush = 1'b1;
        in_data = {32'hDEAD_0001, 32'hDEAD_0000};
        @(negedge clk);
        check("flush in_ready", 64'(in_ready), 64'd0);
        step();
        flush = 1'b0;
        in_data = {32'd300, 32'd310};
        for (int n = 0; n < DEPTH; n++) begin
            @(negedge clk);
            check($sformatf("flush out_valid %0d", n), 64'(out_valid), 64'd0);
            step();
        end
        @(negedge clk);
        check("post-flush out_valid", 64'(out_valid), 64'b11);
        check("post-flush data0", 64'(out_data[31:0]), 64'd314);

        // global stall: lane 1 blocked for 3 cycles
        for (int n = 0; n < 6; n++) begin
            in_data = {32'(400 + n), 32'(500 + n)};
            step();
        end
        in_data = {32'd999, 32'd888};
        out_ready = 2'b01;
        @(negedge clk);
        check("stall asserted", 64'(stall), 64'd1);
        check("stall in_ready", 64'(in_ready), 64'd0);
        snap_v = out_valid;
        snap_d = out_data;
        for (int k = 0; k < 3; k++) begin
            step();
            if (k == 2) out_ready = 2'b11;
            @(negedge clk);
            check($sformatf("frozen valid %0d", k), 64'(out_valid), 64'(snap_v));
            check($sformatf("frozen data %0d", k), out_data, snap_d);
            if (k < 2) check($sformatf("frozen in_ready %0d", k), 64'(in_ready), 64'd0);
        end
`ifdef STALL_COUNTER_EN
        check("counter after stall", 64'(stall_count), 64'd3);
`else
        check("counter after stall", 64'(stall_count), 64'd0);
`endif
        repeat (8) step();

        // simultaneous reset + flush while busy and stalled
        out_ready = 2'b00;
        step();
        reset = 1'b1; flush = 1'b1;
        step();
        reset = 1'b0; flush = 1'b0; in_valid = '0; out_ready = 2'b11;
        @(negedge clk);
        check("rst+flush out_valid", 64'(out_valid), 64'd0);
        check("rst+flush out_data", out_data, 64'd0);
        check("rst+flush stall_count", 64'(stall_count), 64'd0);

        // random traffic
        for (int n = 0; n < 2000; n++) begin
            in_valid = 2'($urandom_range(0, 3));
            for (int i = 0; i < NUM_CH; i++) begin
                if ($urandom_range(0, 7) == 0) in_data[i*DATA_W +: DATA_W] = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
                else in_data[i*DATA_W +: DATA_W] = $urandom;
                out_ready[i] = ($urandom_range(0, 9) < 7);
            end
            flush = ($urandom_range(0, 39) == 0);
            reset = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0; flush = 1'b0; in_valid = '0; out_ready = 2'b11;
        repeat (10) step();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
